// File: rtl/letter_commit_if.sv
// rtl/letter_commit_if.sv - classifier/button inputs and display/scroll outputs of letter_commit
interface letter_commit_if;
    logic        class_valid_in;
    logic [4:0]  class_letter_in;
    logic        btn_up_in;
    logic        btn_down_in;
    logic        data_valid_out;
    logic [4:0]  data_out;
    logic [1:0]  scroll_dir_out;
    logic [10:0] char_count_out;

    modport master (
        output class_valid_in, class_letter_in, btn_up_in, btn_down_in,
        input  data_valid_out, data_out, scroll_dir_out, char_count_out
    );

    modport slave (
        input  class_valid_in, class_letter_in, btn_up_in, btn_down_in,
        output data_valid_out, data_out, scroll_dir_out, char_count_out
    );
endinterface

// File: rtl/letter_commit.sv
// rtl/letter_commit.sv - commits a letter after a stable classifier run; scroll buttons with auto-repeat
module letter_commit #(
    parameter int STABLE_COUNT  = 8,
    parameter int REPEAT_CYCLES = 1_000_000
) (
    input  logic           clk_in,
    input  logic           rst_in,
    letter_commit_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HELD} state_t;

    localparam logic [7:0]  STABLE_LAST = 8'(STABLE_COUNT);
    localparam logic [23:0] REPEAT_LAST = 24'(REPEAT_CYCLES - 1);
    localparam logic [10:0] COUNT_WRAP  = 11'd1024;

    state_t      state_q, state_d;
    logic [4:0]  cand_q, cand_d;
    logic [7:0]  run_q, run_d;
    logic        data_valid_q, data_valid_d;
    logic [4:0]  data_q, data_d;
    logic [10:0] count_q, count_d;
    logic        commit;
    logic [4:0]  code;
    logic        is_letter;

    logic [1:0]  hist_q, hist_d;
    logic        armed_q, armed_d;
    logic        active_q, active_d;
    logic [23:0] timer_q, timer_d;
    logic [1:0]  scroll_q, scroll_d;
    logic        down_only, up_only, prev_down_only, prev_up_only;

    assign code      = bus.class_letter_in;
    assign is_letter = (code >= 5'd1) && (code <= 5'd27);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        commit  = 1'b0;
        if (bus.class_valid_in) begin
            if (code == 5'd0) begin
                state_d = S_IDLE;
                run_d   = 8'd0;
            end else if (is_letter) begin
                case (state_q)
                    S_IDLE: begin
                        state_d = S_TRACK;
                        cand_d  = code;
                        run_d   = 8'd1;
                    end
                    S_TRACK: begin
                        if (code == cand_q) begin
                            run_d = run_q + 8'd1;
                            if (run_q + 8'd1 == STABLE_LAST) begin
                                commit  = 1'b1;
                                state_d = S_HELD;
                            end
                        end else begin
                            cand_d = code;
                            run_d  = 8'd1;
                        end
                    end
                    S_HELD: begin
                        // Holding the committed letter must not re-commit it
                        if (code != cand_q) begin
                            state_d = S_TRACK;
                            cand_d  = code;
                            run_d   = 8'd1;
                        end
                    end
                    default: begin
                        state_d = S_IDLE;
                        run_d   = 8'd0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        data_valid_d = commit;
        data_d       = commit ? cand_q : 5'd0;
        count_d      = count_q;
        if (commit) begin
            count_d = (count_q == COUNT_WRAP) ? 11'd1 : count_q + 11'd1;
        end
    end

    assign down_only      = bus.btn_down_in & ~bus.btn_up_in;
    assign up_only        = bus.btn_up_in & ~bus.btn_down_in;
    assign prev_down_only = hist_q[0] & ~hist_q[1];
    assign prev_up_only   = hist_q[1] & ~hist_q[0];

    // armed_q stays low for the first cycle out of reset so a button held
    // through reset only loads the history instead of counting as a press.
    always_comb begin
        hist_d   = {bus.btn_up_in, bus.btn_down_in};
        armed_d  = 1'b1;
        active_d = 1'b0;
        timer_d  = 24'd0;
        scroll_d = 2'd0;
        if (armed_q && (down_only || up_only)) begin
            if ((down_only && !prev_down_only) || (up_only && !prev_up_only)) begin
                scroll_d = down_only ? 2'd1 : 2'd2;
                active_d = 1'b1;
            end else if (active_q) begin
                active_d = 1'b1;
                if (timer_q == REPEAT_LAST) begin
                    scroll_d = down_only ? 2'd1 : 2'd2;
                end else begin
                    timer_d = timer_q + 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            cand_q       <= 5'd0;
            run_q        <= 8'd0;
            data_valid_q <= 1'b0;
            data_q       <= 5'd0;
            count_q      <= 11'd0;
            hist_q       <= 2'd0;
            armed_q      <= 1'b0;
            active_q     <= 1'b0;
            timer_q      <= 24'd0;
            scroll_q     <= 2'd0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            run_q        <= run_d;
            data_valid_q <= data_valid_d;
            data_q       <= data_d;
            count_q      <= count_d;
            hist_q       <= hist_d;
            armed_q      <= armed_d;
            active_q     <= active_d;
            timer_q      <= timer_d;
            scroll_q     <= scroll_d;
        end
    end

    assign bus.data_valid_out = data_valid_q;
    assign bus.data_out       = data_q;
    assign bus.scroll_dir_out = scroll_q;
    assign bus.char_count_out = count_q;
endmodule

// File: tb/tb_letter_commit.sv
// tb/tb_letter_commit.sv - scoreboard bench for letter_commit
module tb_letter_commit;
    typedef struct {
        int val;
        int cnt;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   exp_cnt = 0;
    int   code_sel = 1;
    exp_t cq[$];
    exp_t sq[$];

    letter_commit_if bus();

    letter_commit #(.STABLE_COUNT(8), .REPEAT_CYCLES(10)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.data_valid_out) begin
            if (cq.size() == 0) begin
                chk("unexpected_commit", int'(bus.data_valid_out), 0);
            end else begin
                e = cq.pop_front();
                chk("commit_code", int'(bus.data_out), e.val);
                chk("commit_count", int'(bus.char_count_out), e.cnt);
                chk("commit_cycle", cyc, e.cyc);
            end
        end else if (cq.size() > 0 && cq[0].cyc <= cyc) begin
            chk("commit_missing", int'(bus.data_valid_out), 1);
            void'(cq.pop_front());
        end
        if (bus.scroll_dir_out != 2'd0) begin
            if (sq.size() == 0) begin
                chk("unexpected_scroll", int'(bus.scroll_dir_out), 0);
            end else begin
                e = sq.pop_front();
                chk("scroll_dir", int'(bus.scroll_dir_out), e.val);
                chk("scroll_cycle", cyc, e.cyc);
            end
        end else if (sq.size() > 0 && sq[0].cyc <= cyc) begin
            chk("scroll_missing", int'(bus.scroll_dir_out), sq[0].val);
            void'(sq.pop_front());
        end
    end

    task automatic send(input int code, input bit commit);
        @(negedge clk);
        bus.class_valid_in  = 1'b1;
        bus.class_letter_in = 5'(code);
        if (commit) begin
            exp_cnt = (exp_cnt == 1024) ? 1 : exp_cnt + 1;
            cq.push_back('{val: code, cnt: exp_cnt, cyc: cyc + 1});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.class_valid_in  = 1'b0;
            bus.class_letter_in = 5'd0;
        end
    endtask

    task automatic expect_scroll(input int dir, input int at);
        sq.push_back('{val: dir, cnt: 0, cyc: at});
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"}, int'(bus.data_valid_out), 0);
        chk({tag, "_data"}, int'(bus.data_out), 0);
        chk({tag, "_scroll"}, int'(bus.scroll_dir_out), 0);
        chk({tag, "_count"}, int'(bus.char_count_out), 0);
    endtask

    initial begin
        int seq033[11];
        int base;
        rst = 1'b1;
        bus.class_valid_in  = 1'b0;
        bus.class_letter_in = 5'd0;
        bus.btn_up_in       = 1'b0;
        bus.btn_down_in     = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rst = 1'b0;

        // Eight strobes commit once; a held letter does not recommit
        for (int i = 0; i < 8; i++) send(5, i == 7);
        for (int i = 0; i < 20; i++) send(5, 1'b0);
        idle(3);
        chk("count_after_first", int'(bus.char_count_out), 1);

        seq033 = '{3, 3, 3, 4, 4, 4, 4, 4, 4, 4, 4};
        for (int i = 0; i < 11; i++) send(seq033[i], i == 10);
        idle(2);

        for (int i = 0; i < 7; i++) send(5, 1'b0);
        send(0, 1'b0);
        for (int i = 0; i < 7; i++) send(5, 1'b0);
        idle(4);
        send(5, 1'b1);
        idle(2);

        for (int i = 0; i < 8; i++) begin
            send(7, i == 7);
            if (i < 7) send(30, 1'b0);
        end
        idle(2);
        chk("count_after_035", int'(bus.char_count_out), 4);

        while (exp_cnt < 1024) begin
            for (int j = 0; j < 8; j++) send(code_sel, j == 7);
            code_sel = 3 - code_sel;
        end
        idle(2);
        chk("count_at_1024", int'(bus.char_count_out), 1024);
        for (int j = 0; j < 8; j++) send(code_sel, j == 7);
        idle(2);
        chk("count_wrap_to_1", int'(bus.char_count_out), 1);

        // Reset mid-run discards the partial run
        for (int i = 0; i < 6; i++) send(9, 1'b0);
        @(negedge clk);
        bus.class_valid_in = 1'b0;
        rst = 1'b1;
        exp_cnt = 0;
        @(negedge clk);
        chk_outputs_zero("midrun_reset");
        rst = 1'b0;
        send(9, 1'b0);
        send(9, 1'b0);
        idle(4);
        chk("count_after_reset", int'(bus.char_count_out), 0);

        // Auto-repeat every 10 cycles, then both buttons suppress output
        @(negedge clk);
        bus.btn_down_in = 1'b1;
        base = cyc;
        expect_scroll(1, base + 1);
        expect_scroll(1, base + 11);
        expect_scroll(1, base + 21);
        expect_scroll(1, base + 31);
        repeat (35) @(negedge clk);
        bus.btn_up_in = 1'b1;
        repeat (15) @(negedge clk);
        chk("both_held_scroll", int'(bus.scroll_dir_out), 0);
        bus.btn_up_in = 1'b0;
        expect_scroll(1, cyc + 1);
        repeat (3) @(negedge clk);
        bus.btn_down_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.btn_up_in = 1'b1;
        base = cyc;
        expect_scroll(2, base + 1);
        expect_scroll(2, base + 11);
        repeat (12) @(negedge clk);
        bus.btn_up_in = 1'b0;
        repeat (3) @(negedge clk);

        // Button held through reset is not a press
        bus.btn_down_in = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_outputs_zero("btn_reset");
        rst = 1'b0;
        repeat (15) @(negedge clk);
        bus.btn_down_in = 1'b0;
        repeat (2) @(negedge clk);
        bus.btn_down_in = 1'b1;
        expect_scroll(1, cyc + 1);
        repeat (2) @(negedge clk);
        bus.btn_down_in = 1'b0;

        idle(20);
        chk("commit_queue_drained", cq.size(), 0);
        chk("scroll_queue_drained", sq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
